// File: rtl/chacha20_stream_xor.sv
// chacha20_stream_xor: requests 512-bit keystream blocks from chacha20_top and XORs them word by word
// onto a 32-bit valid/ready stream, stepping the block counter every 16 words.
module chacha20_stream_xor #(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int WORD_W          = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              msg_start,
    input  logic [31:0]                       msg_counter,
    output logic                              ks_start,
    output logic [31:0]                       ks_counter,
    input  logic [WORDS_PER_BLOCK*WORD_W-1:0] ks_keystream,
    input  logic                              ks_done,
    input  logic [WORD_W-1:0]                 in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [WORD_W-1:0]                 out_data,
    output logic                              out_valid,
    output logic                              out_last,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              ctr_overflow
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

    generate
        if (WORDS_PER_BLOCK != 16 || WORD_W != 32) begin : g_param_check
            $error("chacha20_stream_xor supports only WORDS_PER_BLOCK=16 and WORD_W=32");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_STREAM,
        S_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_ctr;
    logic [WORD_W-1:0]  r_buf [WORDS_PER_BLOCK];
    logic [IDX_W-1:0]   r_idx;
    logic [WORD_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_overflow;

    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_start_ok;
    logic               w_last_word;
    logic               w_ctr_max;

    // A new message may only begin once the previous one has fully drained from the output register.
    assign w_start_ok  = msg_start && !r_out_valid;
    assign w_in_ready  = (r_state == S_STREAM) && (!r_out_valid || out_ready);
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_last_word = (r_idx == IDX_W'(WORDS_PER_BLOCK - 1));
    assign w_ctr_max   = (r_ctr == 32'hFFFF_FFFF);

    assign ks_start     = (r_state == S_REQ);
    assign ks_counter   = r_ctr;
    assign in_ready     = w_in_ready;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign ctr_overflow = r_overflow;
    assign busy         = ((r_state != S_IDLE) && (r_state != S_ERROR)) || r_out_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (w_start_ok) w_next_state = S_REQ;
            end
            S_REQ: begin
                if (ks_done) w_next_state = S_GAP;
            end
            // One idle cycle with ks_start low so chacha20_top sees a fresh rising request.
            S_GAP: begin
                w_next_state = S_STREAM;
            end
            S_STREAM: begin
                if (w_in_fire) begin
                    if (in_last) begin
                        w_next_state = S_IDLE;
                    end else if (w_last_word) begin
                        w_next_state = w_ctr_max ? S_ERROR : S_REQ;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ctr       <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;

            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (w_start_ok) begin
                        r_ctr      <= msg_counter;
                        r_overflow <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (ks_done) begin
                        r_idx <= '0;
                        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                            r_buf[i] <= ks_keystream[i*WORD_W +: WORD_W];
                        end
                    end
                end
                S_STREAM: begin
                    if (w_in_fire) begin
                        r_idx <= r_idx + 1'b1;
                        if (!in_last && w_last_word) begin
                            if (w_ctr_max) r_overflow <= 1'b1;
                            else           r_ctr      <= r_ctr + 32'd1;
                        end
                    end
                end
                default: begin
                end
            endcase

            // Output skid: a new word reloads the register, otherwise a downstream accept empties it.
            if (w_in_fire) begin
                r_out_data  <= in_data ^ r_buf[r_idx];
                r_out_last  <= in_last;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chacha20_stream_xor.sv
// tb_chacha20_stream_xor: drives random messages through chacha20_stream_xor against a stub keystream
// source and compares every output word with a word-index reference model.
module tb_chacha20_stream_xor;

    logic         clk = 1'b0;
    logic         reset;
    logic         msg_start;
    logic [31:0]  msg_counter;
    logic         ks_start;
    logic [31:0]  ks_counter;
    logic [511:0] ks_keystream = '0;
    logic         ks_done = 1'b0;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         ctr_overflow;

    int checks = 0;
    int failures = 0;

    logic [32:0] gotQ [$];
    logic [32:0] expQ [$];
    logic [31:0] inQ [$];
    logic [31:0] reqQ [$];
    int          gapQ [$];
    int          unstableCount = 0;

    logic holdLow = 1'b0;
    logic randMode = 1'b0;
    logic rndBit = 1'b1;
    int   forceReq = 0;
    int   forceSeen = 0;
    int   stubCnt = 0;
    logic prevKs = 1'b0;
    logic [31:0] prevCtr = '0;
    int   lowRun = 0;

    assign out_ready = holdLow ? 1'b0 : (randMode ? rndBit : 1'b1);

    chacha20_stream_xor dut (
        .clk          (clk),
        .reset        (reset),
        .msg_start    (msg_start),
        .msg_counter  (msg_counter),
        .ks_start     (ks_start),
        .ks_counter   (ks_counter),
        .ks_keystream (ks_keystream),
        .ks_done      (ks_done),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .ctr_overflow (ctr_overflow)
    );

    always #5 clk = ~clk;

    // Keystream word i of block c is {c[15:0], i}.
    function automatic logic [31:0] ks_word(input logic [31:0] blk, input int i);
        return {blk[15:0], 16'(i)};
    endfunction

    // Stub chacha20_top: ks_done pulses on the 5th cycle of a held request; forced pulses carry junk.
    always begin
        @(posedge clk);
        #1;
        if (ks_done) begin
            ks_done = 1'b0;
            stubCnt = 0;
        end else if (forceReq != forceSeen) begin
            forceSeen = forceReq;
            for (int i = 0; i < 16; i++) ks_keystream[i*32 +: 32] = $urandom;
            ks_done = 1'b1;
        end else if (ks_start) begin
            stubCnt++;
            if (stubCnt == 5) begin
                for (int i = 0; i < 16; i++) ks_keystream[i*32 +: 32] = ks_word(ks_counter, i);
                ks_done = 1'b1;
            end
        end else begin
            stubCnt = 0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        rndBit = ($urandom_range(0, 3) != 0);
    end

    // Monitor: inputs settle at posedge+1, so a negedge sample predicts the next edge's handshakes.
    always @(negedge clk) begin
        if (out_valid && out_ready && !reset) gotQ.push_back({out_last, out_data});
        if (ks_start && !prevKs) begin
            reqQ.push_back(ks_counter);
            gapQ.push_back(lowRun);
        end
        if (ks_start && prevKs && ks_counter !== prevCtr) unstableCount++;
        lowRun  = ks_start ? 0 : lowRun + 1;
        prevKs  = ks_start;
        prevCtr = ks_counter;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got still-running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gotQ.delete();
        expQ.delete();
        inQ.delete();
        reqQ.delete();
        gapQ.delete();
        unstableCount = 0;
    endtask

    task automatic start_msg(input logic [31:0] c0);
        msg_start   = 1'b1;
        msg_counter = c0;
        tick();
        msg_start   = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] c0, input int n, input bit withLast, input bit bubbles,
                              input bit useFixed, input logic [31:0] fixedBase, input int pulseK,
                              output bit to);
        int cyc;
        bit fired;
        to = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = useFixed ? fixedBase + 32'(k) : $urandom;
            in_last  = withLast && (k == n - 1);
            if (k == pulseK) begin
                msg_start   = 1'b1;
                msg_counter = 32'd99;
            end
            inQ.push_back(in_data);
            expQ.push_back({in_last, in_data ^ ks_word(c0 + 32'(k / 16), k % 16)});
            cyc = 0;
            fired = 1'b0;
            while (!fired && cyc < 200) begin
                @(negedge clk);
                fired = in_ready;
                tick();
                msg_start = 1'b0;
                cyc++;
            end
            if (!fired) begin
                to = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(output bit to);
        int c;
        to = 1'b1;
        c = 0;
        while (c < 300) begin
            @(negedge clk);
            if (!busy) begin
                to = 1'b0;
                break;
            end
            c++;
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (ks_start !== 1'b0)     begin failures++; $display("[TB] FAIL reset_ks_start: got %b expected 0", ks_start); end
        checks++; if (ks_counter !== 32'd0)  begin failures++; $display("[TB] FAIL reset_ks_counter: got %h expected 0", ks_counter); end
        checks++; if (in_ready !== 1'b0)     begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0)    begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0)     begin failures++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (out_data !== 32'd0)    begin failures++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ctr_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ctr_overflow: got %b expected 0", ctr_overflow); end
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle: got busy=%b in_ready=%b expected 0/0", busy, in_ready); end
        tick();
    endtask

    task automatic test_single_block();
        bit to1, to2;
        clear_logs();
        start_msg(32'd1);
        send_words(32'd1, 3, 1'b1, 1'b0, 1'b1, 32'h000000A0, -1, to1);
        wait_drain(to2);
        checks++; if (to1 || to2) begin failures++; $display("[TB] FAIL t1_timeout: got send=%b drain=%b expected 0/0", to1, to2); end
        checks++; if (gotQ.size() != 3) begin failures++; $display("[TB] FAIL t1_count: got %0d expected 3", gotQ.size()); end
        if (gotQ.size() == 3) begin
            checks++; if (gotQ[0] !== 33'h0_000100A0) begin failures++; $display("[TB] FAIL t1_word0: got %h expected 0_000100a0", gotQ[0]); end
            checks++; if (gotQ[1] !== 33'h0_000100A0) begin failures++; $display("[TB] FAIL t1_word1: got %h expected 0_000100a0", gotQ[1]); end
            checks++; if (gotQ[2] !== 33'h1_000100A0) begin failures++; $display("[TB] FAIL t1_word2: got %h expected 1_000100a0", gotQ[2]); end
        end
        checks++; if (reqQ.size() != 1) begin failures++; $display("[TB] FAIL t1_requests: got %0d expected 1", reqQ.size()); end
        if (reqQ.size() >= 1) begin
            checks++; if (reqQ[0] !== 32'd1) begin failures++; $display("[TB] FAIL t1_ks_counter: got %h expected 1", reqQ[0]); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ks_start !== 1'b0) begin failures++; $display("[TB] FAIL t1_idle: got busy=%b ks_start=%b expected 0/0", busy, ks_start); end
        tick();
    endtask

    task automatic test_two_blocks();
        bit to1, to2;
        clear_logs();
        randMode = 1'b1;
        start_msg(32'd7);
        send_words(32'd7, 20, 1'b1, 1'b1, 1'b0, 32'd0, -1, to1);
        wait_drain(to2);
        randMode = 1'b0;
        checks++; if (to1 || to2) begin failures++; $display("[TB] FAIL t2_timeout: got send=%b drain=%b expected 0/0", to1, to2); end
        checks++; if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL t2_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL t2_word%0d: got %h expected %h", i, gotQ[i], expQ[i]); end
        end
        if (gotQ.size() > 16) begin
            checks++; if ((gotQ[16][31:0] ^ inQ[16]) !== 32'h00080000) begin failures++; $display("[TB] FAIL t2_word16_key: got %h expected 00080000", gotQ[16][31:0] ^ inQ[16]); end
        end
        checks++; if (reqQ.size() != 2) begin failures++; $display("[TB] FAIL t2_requests: got %0d expected 2", reqQ.size()); end
        if (reqQ.size() == 2) begin
            checks++; if (reqQ[0] !== 32'd7 || reqQ[1] !== 32'd8) begin failures++; $display("[TB] FAIL t2_ks_counters: got %h,%h expected 7,8", reqQ[0], reqQ[1]); end
            checks++; if (gapQ[1] < 1) begin failures++; $display("[TB] FAIL t2_ks_start_gap: got %0d expected >=1", gapQ[1]); end
        end
        checks++; if (unstableCount != 0) begin failures++; $display("[TB] FAIL t2_ks_counter_stable: got %0d changes expected 0", unstableCount); end
    endtask

    task automatic test_backpressure();
        bit to1, to2, toStall;
        int bad, acc;
        logic [31:0] c0;
        logic [31:0] snapD;
        logic snapL, snapV;
        clear_logs();
        c0 = 32'($urandom_range(100, 1000));
        bad = 0;
        acc = 0;
        toStall = 1'b1;
        snapD = '0;
        snapL = 1'b0;
        snapV = 1'b0;
        start_msg(c0);
        fork
            send_words(c0, 20, 1'b1, 1'b0, 1'b0, 32'd0, -1, to1);
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (gotQ.size() >= 3) begin
                        toStall = 1'b0;
                        break;
                    end
                end
                tick();
                holdLow = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (i == 1) begin
                        snapD = out_data;
                        snapL = out_last;
                        snapV = out_valid;
                    end
                    if (i >= 2 && (out_data !== snapD || out_last !== snapL || out_valid !== 1'b1)) bad++;
                    if (i >= 1 && in_ready) acc++;
                end
                tick();
                holdLow = 1'b0;
            end
        join
        wait_drain(to2);
        checks++; if (to1 || to2 || toStall) begin failures++; $display("[TB] FAIL t3_timeout: got send=%b drain=%b stall=%b expected 0/0/0", to1, to2, toStall); end
        checks++; if (snapV !== 1'b1) begin failures++; $display("[TB] FAIL t3_stall_valid: got %b expected 1", snapV); end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL t3_hold_stable: got %0d changed cycles expected 0", bad); end
        checks++; if (acc != 0) begin failures++; $display("[TB] FAIL t3_in_ready_stall: got %0d ready cycles expected 0", acc); end
        checks++; if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL t3_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL t3_word%0d: got %h expected %h", i, gotQ[i], expQ[i]); end
        end
    endtask

    task automatic test_overflow();
        bit to1, to2;
        int acc;
        logic [31:0] c1;
        clear_logs();
        start_msg(32'hFFFFFFFF);
        send_words(32'hFFFFFFFF, 16, 1'b0, 1'b1, 1'b0, 32'd0, -1, to1);
        wait_drain(to2);
        checks++; if (to1 || to2) begin failures++; $display("[TB] FAIL t4_timeout: got send=%b drain=%b expected 0/0", to1, to2); end
        checks++; if (ctr_overflow !== 1'b1) begin failures++; $display("[TB] FAIL t4_overflow_set: got %b expected 1", ctr_overflow); end
        checks++; if (gotQ.size() != 16) begin failures++; $display("[TB] FAIL t4_count: got %0d expected 16", gotQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL t4_word%0d: got %h expected %h", i, gotQ[i], expQ[i]); end
        end
        acc = 0;
        in_valid = 1'b1;
        in_data  = $urandom;
        in_last  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (acc != 0) begin failures++; $display("[TB] FAIL t4_in_ready_error: got %0d ready cycles expected 0", acc); end
        checks++; if (reqQ.size() != 1) begin failures++; $display("[TB] FAIL t4_requests: got %0d expected 1", reqQ.size()); end
        clear_logs();
        c1 = 32'($urandom_range(0, 5000));
        start_msg(c1);
        @(negedge clk);
        checks++; if (ctr_overflow !== 1'b0) begin failures++; $display("[TB] FAIL t4_overflow_clear: got %b expected 0", ctr_overflow); end
        tick();
        send_words(c1, 3, 1'b1, 1'b0, 1'b0, 32'd0, -1, to1);
        wait_drain(to2);
        checks++; if (to1 || to2 || reqQ.size() != 1) begin failures++; $display("[TB] FAIL t4_restart: got send=%b drain=%b reqs=%0d expected 0/0/1", to1, to2, reqQ.size()); end
        if (reqQ.size() == 1) begin
            checks++; if (reqQ[0] !== c1) begin failures++; $display("[TB] FAIL t4_restart_counter: got %h expected %h", reqQ[0], c1); end
        end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL t4_restart_word%0d: got %h expected %h", i, gotQ[i], expQ[i]); end
        end
    endtask

    task automatic test_reset_in_req();
        bit seen;
        clear_logs();
        start_msg(32'($urandom_range(0, 60000)));
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ks_start) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("[TB] FAIL t5_request_seen: got 0 expected 1"); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ks_start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL t5_abort: got ks_start=%b out_valid=%b busy=%b expected 0/0/0", ks_start, out_valid, busy); end
        tick();
        forceReq++;
        repeat (4) tick();
        @(negedge clk);
        checks++; if (ks_start !== 1'b0 || busy !== 1'b0 || gotQ.size() != 0 || reqQ.size() != 1) begin failures++; $display("[TB] FAIL t5_late_done: got ks_start=%b busy=%b outs=%0d reqs=%0d expected 0/0/0/1", ks_start, busy, gotQ.size(), reqQ.size()); end
        tick();
    endtask

    task automatic test_msg_start_ignored();
        bit to1, to2;
        logic [31:0] c0;
        clear_logs();
        randMode = 1'b1;
        c0 = 32'($urandom_range(0, 60000));
        start_msg(c0);
        send_words(c0, 20, 1'b1, 1'b1, 1'b0, 32'd0, 5, to1);
        wait_drain(to2);
        randMode = 1'b0;
        checks++; if (to1 || to2) begin failures++; $display("[TB] FAIL t6_timeout: got send=%b drain=%b expected 0/0", to1, to2); end
        checks++; if (reqQ.size() != 2) begin failures++; $display("[TB] FAIL t6_requests: got %0d expected 2", reqQ.size()); end
        if (reqQ.size() == 2) begin
            checks++; if (reqQ[0] !== c0 || reqQ[1] !== c0 + 32'd1) begin failures++; $display("[TB] FAIL t6_ks_counters: got %h,%h expected %h,%h", reqQ[0], reqQ[1], c0, c0 + 32'd1); end
        end
        checks++; if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL t6_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL t6_word%0d: got %h expected %h", i, gotQ[i], expQ[i]); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        msg_start   = 1'b0;
        msg_counter = '0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        tick();
        test_reset();
        test_single_block();
        test_two_blocks();
        test_backpressure();
        test_overflow();
        test_reset_in_req();
        test_msg_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
